// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Pointer width helper: one extra MSB beyond the address separates full from empty.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with count, almost flags, sticky errors.
// Ports: clk, rst_n, wr_en/datain, rd_en/dataout, full/empty, almost_full/
// almost_empty, count, overflow/underflow, clr_err. FIFO_FWFT_EN: fall-through.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       datain,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dataout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);

    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [AW:0] AF_T = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_T = (AW+1)'(AE_THRESH);

    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
        $error("fifo_sync_param: AE_THRESH out of range");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 4");
    end

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rdata;

    // Flags derive only from registered state, never from wr_en/rd_en.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (datain),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Sticky errors: a set condition beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow <= 1'b1;
            else if (clr_err)   overflow <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (clr_err)   underflow <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign dataout = empty ? '0 : rdata;
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= rdata;
        end
    end

    assign dataout = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (DEPTH=8, AF=6, AE=2).
// Queue-based reference model; directed plan steps plus random traffic.
module tb_fifo_sync_param;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] datain = '0;
    logic [W-1:0] dataout;
    logic         full, empty, almost_full, almost_empty;
    logic [3:0]   count;
    logic         overflow, underflow;

    fifo_sync_param #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .datain       (datain),
        .rd_en        (rd_en),
        .dataout      (dataout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q [$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    logic [W-1:0] m_dout = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ":count"}, 32'(count), 32'(n));
        chk({tag, ":full"}, 32'(full), 32'(n == D));
        chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ":af"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ":ae"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ":unf"}, 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
        if (n > 0) chk({tag, ":dout"}, 32'(dataout), 32'(q[0]));
`else
        chk({tag, ":dout"}, 32'(dataout), 32'(m_dout));
`endif
    endtask

    task automatic cyc(input logic w, input logic [W-1:0] d,
                       input logic r, input logic c, input string tag);
        bit was_full, was_empty;
        wr_en = w; datain = d; rd_en = r; clr_err = c;
        @(posedge clk);
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        if (w && was_full) m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
        if (r && was_empty) m_unf = 1'b1;
        else if (c)         m_unf = 1'b0;
        if (r && !was_empty) m_dout = q.pop_front();
        if (w && !was_full)  q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    task automatic drain();
        while (q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0, "drain");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cyc(1'b1, W'(8'h30 + i), 1'b0, 1'b0, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_count", 32'(count), 32'd0);
        chk("rst_async_empty", 32'(empty), 32'd1);
        chk("rst_async_dout", 32'(dataout), 32'd0);
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'h11, 1'b0, 1'b0, "post_rst_wr");
        cyc(1'b0, '0, 1'b1, 1'b0, "post_rst_rd");
`ifndef FIFO_FWFT_EN
        chk("post_rst_data", 32'(dataout), 32'h11);
`endif

        // Fill and drain
        for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), 1'b0, 1'b0, "fill");
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        drain();
        chk("drain_empty", 32'(empty), 32'd1);

        // Thresholds
        cyc(1'b1, 8'hA0, 1'b0, 1'b0, "th");
        cyc(1'b1, 8'hA1, 1'b0, 1'b0, "th");
        chk("th_ae_at2", 32'(almost_empty), 32'd1);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0, "th");
        chk("th_ae_at3", 32'(almost_empty), 32'd0);
        for (int i = 3; i < 6; i++) cyc(1'b1, W'(8'hA0 + i), 1'b0, 1'b0, "th");
        chk("th_af_at6", 32'(almost_full), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b0, "th_rd");
        chk("th_af_at5", 32'(almost_full), 32'd0);

        // Boundary simultaneity
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(8'hB0 + i), 1'b0, 1'b0, "top");
        chk("sim_full", 32'(full), 32'd1);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0, "sim_full_rw");
        chk("sim_full_cnt", 32'(count), 32'd7);
        chk("sim_full_ovf", 32'(overflow), 32'd1);
        drain();
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, "sim_empty_rw");
        chk("sim_empty_cnt", 32'(count), 32'd1);
        chk("sim_empty_unf", 32'(underflow), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1, "clr");
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);
        drain();

        // Wrap-around with interleaved pairs
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, W'($urandom), 1'b0, 1'b0, "wrap_wr");
            chk("wrap_cnt_le1", 32'(count <= 4'd1), 32'd1);
            cyc(1'b0, '0, 1'b1, 1'b0, "wrap_rd");
            chk("wrap_cnt_le1", 32'(count <= 4'd1), 32'd1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), W'($urandom),
                1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                "rand");
        end
        drain();

`ifdef FIFO_FWFT_EN
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, "fwft_wr");
        chk("fwft_dout", 32'(dataout), 32'hA5);
        cyc(1'b0, '0, 1'b0, 1'b0, "fwft_hold");
        chk("fwft_dout_hold", 32'(dataout), 32'hA5);
        cyc(1'b0, '0, 1'b1, 1'b0, "fwft_pop");
        chk("fwft_empty", 32'(empty), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Single-clock, parametrised FIFO. The next generation of the team's FIFO family.
- Generalises width and depth over the fixed 8-bit FIFO.
- Adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Used as the same-domain buffer between producer and consumer logic that share one clock.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; must be a power of two, >=4.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- datain  input  WIDTH  write data, sampled when a write is accepted.
- rd_en  input  1  read request.
- dataout  output  WIDTH  read data.
- full  output  1  DEPTH entries held.
- empty  output  1  zero entries held.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- clr_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- AW = $clog2(DEPTH). Pointers are AW+1 bits; the extra MSB distinguishes full from empty.
  - full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]).
  - empty = (wr_ptr == rd_ptr).
- Reset (rst_n low, asynchronous, any time):
  - Pointers and count go to 0; empty=1, full=0, almost_empty=1, almost_full=0.
  - dataout=0; overflow and underflow = 0.
  - Memory contents are not reset.
- Accepted write = wr_en && !full. Stores datain at wr_ptr and increments wr_ptr; wraps naturally at 2*DEPTH.
- Accepted read = rd_en && !empty. Increments rd_ptr.
- Full and read+write in the same cycle: read accepted, write rejected. overflow sets; count becomes DEPTH-1.
- Empty and read+write in the same cycle: write accepted, read rejected. underflow sets; count becomes 1.
- Both accepted in the same cycle: count unchanged; both pointers advance.
- All flags and count are registered and reflect state after the edge. No combinational path from wr_en/rd_en to any flag.
- dataout (default, registered read):
  - Takes mem[rd_ptr] on the edge that accepts a read, so it is valid one cycle after rd_en.
  - Holds its value otherwise, including after rejected reads.
- overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both clear only on clr_err=1 or reset.
  - If clr_err and a set condition occur in the same cycle, set wins.
- Thresholds outside 0..DEPTH are illegal. The implementation flags them with an elaboration-time $error.

Optional Feature:
- Macro: FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - dataout continuously presents mem[rd_ptr] whenever !empty, with zero read latency.
  - rd_en acts as a pop acknowledge.
  - A word written into an empty FIFO appears on dataout the cycle after the write edge.
  - dataout is don't-care while empty.
- Undefined: registered-read behaviour above.
- Flag, count and error semantics are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - default constants FIFO_WIDTH_DEF=8, FIFO_DEPTH_DEF=16;
  - a function computing pointer width from depth.
- Sub-module fifo_mem: simple dual-port register array with write port (we, waddr, wdata) and asynchronous read address port.
- fifo_sync_param owns pointers, count, flags and the output register.

Test Plan:
- Reset mid-operation: write 5 words, assert rst_n low between edges. Immediately count=0, empty=1, dataout=0; then write 0x11 and read it back, giving 0x11.
- Fill/drain, WIDTH=8, DEPTH=8: write 0x01..0x08, giving full=1, count=8. Read 8 times, giving 0x01..0x08 in order each one cycle after rd_en, then empty=1.
- Thresholds, AF_THRESH=6, AE_THRESH=2: after 2 writes almost_empty=1; after 3 writes almost_empty=0; after 6 writes almost_full=1; after 1 read almost_full=0.
- Boundary simultaneity:
  - Full plus wr_en+rd_en: count goes 8 to 7, overflow=1, oldest word read.
  - Empty plus both: count goes 0 to 1, underflow=1.
  - clr_err then clears both.
- Wrap-around: 20 interleaved write/read pairs on DEPTH=8 with random data. Data matches a scoreboard; count never exceeds 1.
- FIFO_FWFT_EN build: write 0xA5 into empty FIFO; next cycle dataout=0xA5 with no rd_en; pop; empty=1.
